// File: rtl/rx_check_len.sv
// Receive checker: counts bytes of a descending-pattern packet, verifies pattern/tkeep/final zero, then emits a 5-byte report.
// Latency: report byte 0 valid 1 cycle after the tlast beat is accepted; 6-cycle minimum turnaround with o_tready=1.
// Backpressure: i_tready high only while receiving; report bytes are held on o_tdata until o_tvalid&o_tready.
module rx_check_len #(
   parameter bit CHECK_LAST_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        i_tready,
   input  logic        i_tvalid,
   input  logic [31:0] i_tdata,
   input  logic [3:0]  i_tkeep,
   input  logic        i_tlast,
   input  logic        o_tready,
   output logic        o_tvalid,
   output logic [7:0]  o_tdata
);

   typedef enum logic [2:0] {RX, TX0, TX1, TX2, TX3, TX4} state_t;

   state_t      state, state_nxt;
   logic [31:0] count;
   logic [7:0]  status;
   logic        have_prev;
   logic [7:0]  prev_byte;

   logic        beat_acc;
   logic        tx_acc;
   logic        walk_have_prev;
   logic [7:0]  walk_prev;
   logic        pat_err;
   logic        keep_illegal;
   logic [2:0]  keep_cnt;
   logic [32:0] count_sum;
   logic [31:0] count_beat;
   logic        sat_err;
   logic        last_err;
   logic [7:0]  status_beat;
   logic [7:0]  tx_next_byte;

   assign i_tready = (state == RX);
   assign beat_acc = (state == RX) && i_tvalid;
   assign tx_acc   = o_tvalid && o_tready;

   // Walk the kept lanes in stream order, checking each byte against its predecessor.
   always_comb begin
      logic [7:0] cur;
      walk_have_prev = have_prev;
      walk_prev      = prev_byte;
      pat_err        = 1'b0;
      cur            = 8'h00;
      for (int k = 0; k < 4; k++) begin
         if (i_tkeep[k]) begin
            cur = i_tdata[8*k +: 8];
            if (walk_have_prev && (cur != 8'(walk_prev - 8'd1))) begin
               pat_err = 1'b1;
            end
            walk_prev      = cur;
            walk_have_prev = 1'b1;
         end
      end
   end

   // Keep legality, byte count with saturation, and the assembled status for this beat.
   always_comb begin
      case (i_tkeep)
         4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: keep_illegal = 1'b0;
         default:                                     keep_illegal = 1'b1;
      endcase
      keep_cnt    = {2'b00, i_tkeep[0]} + {2'b00, i_tkeep[1]}
                  + {2'b00, i_tkeep[2]} + {2'b00, i_tkeep[3]};
      count_sum   = {1'b0, count} + {30'd0, keep_cnt};
      sat_err     = count_sum[32];
      count_beat  = sat_err ? 32'hFFFF_FFFF : count_sum[31:0];
      last_err    = CHECK_LAST_ZERO && i_tlast && walk_have_prev && (walk_prev != 8'h00);
      status_beat = status | {4'b0000, sat_err, last_err, keep_illegal, pat_err};
   end

   // Byte to present after the current report byte is taken.
   always_comb begin
      case (state)
         TX0:     tx_next_byte = count[15:8];
         TX1:     tx_next_byte = count[23:16];
         TX2:     tx_next_byte = count[31:24];
         TX3:     tx_next_byte = status;
         default: tx_next_byte = 8'h00;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= RX;
      else       state <= state_nxt;
   end

   // Next state: leave RX on an accepted tlast beat, step through report bytes on each transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         RX:      if (beat_acc && i_tlast) state_nxt = TX0;
         TX0:     if (tx_acc) state_nxt = TX1;
         TX1:     if (tx_acc) state_nxt = TX2;
         TX2:     if (tx_acc) state_nxt = TX3;
         TX3:     if (tx_acc) state_nxt = TX4;
         TX4:     if (tx_acc) state_nxt = RX;
         default: state_nxt = RX;
      endcase
   end

   // Packet accumulators and registered report outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count     <= 32'd0;
         status    <= 8'h00;
         have_prev <= 1'b0;
         prev_byte <= 8'h00;
         o_tvalid  <= 1'b0;
         o_tdata   <= 8'h00;
      end else if (beat_acc) begin
         count     <= count_beat;
         status    <= status_beat;
         have_prev <= walk_have_prev;
         prev_byte <= walk_prev;
         if (i_tlast) begin
            o_tvalid <= 1'b1;
            o_tdata  <= count_beat[7:0];
         end
      end else if (tx_acc) begin
         if (state == TX4) begin
            o_tvalid  <= 1'b0;
            o_tdata   <= 8'h00;
            count     <= 32'd0;
            status    <= 8'h00;
            have_prev <= 1'b0;
            prev_byte <= 8'h00;
         end else begin
            o_tdata <= tx_next_byte;
         end
      end
   end

endmodule

// File: tb/tb_rx_check_len.sv
// Bench for rx_check_len: two instances (final-zero check on and off) share all stimulus.
// A packet-level model predicts each 5-byte report; a per-cycle monitor checks handshake and bytes.
// Directed packets cover lengths, trailers, corruption, illegal keep, wrap, stalls and reset.
module tb_rx_check_len;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_tvalid;
   logic [31:0] i_tdata;
   logic [3:0]  i_tkeep;
   logic        i_tlast;
   logic        o_tready;
   logic        i_tready1, i_tready0;
   logic        o_tvalid1, o_tvalid0;
   logic [7:0]  o_tdata1, o_tdata0;

   beat_t       pkt[$];
   logic [7:0]  exp1[$];
   logic [7:0]  exp0[$];
   int          checks = 0;
   int          errors = 0;
   bit          pending = 1'b0;
   int          idx = 0;
   bit          stalled = 1'b0;
   logic [7:0]  held1, held0;
   bit          rnd_mode = 1'b0;

   always #5 clk = ~clk;

   rx_check_len #(.CHECK_LAST_ZERO(1'b1)) dut (
      .clk(clk), .rstn(rstn), .i_tready(i_tready1), .i_tvalid(i_tvalid),
      .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
      .o_tready(o_tready), .o_tvalid(o_tvalid1), .o_tdata(o_tdata1)
   );

   rx_check_len #(.CHECK_LAST_ZERO(1'b0)) dut_nz (
      .clk(clk), .rstn(rstn), .i_tready(i_tready0), .i_tvalid(i_tvalid),
      .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
      .o_tready(o_tready), .o_tvalid(o_tvalid0), .o_tdata(o_tdata0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Report predicted from the flattened byte stream of the current packet: {status, count}.
   function automatic logic [39:0] model(input bit clz);
      logic [7:0] b[$];
      logic [7:0] st;
      int         n;
      st = 8'h00;
      foreach (pkt[i]) begin
         if (!(pkt[i].k inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) st[1] = 1'b1;
         for (int k = 0; k < 4; k++)
            if (pkt[i].k[k]) b.push_back(pkt[i].d[8*k +: 8]);
      end
      n = b.size();
      for (int i = 1; i < n; i++)
         if (b[i] != 8'(b[i-1] - 8'd1)) st[0] = 1'b1;
      if (clz && n > 0 && b[n-1] != 8'h00) st[2] = 1'b1;
      return {st, 32'(n)};
   endfunction

   // Clean descending packet of len bytes ending in 0x00; optional keep=0 tlast trailer.
   task automatic build_pkt(input int len, input bit trailer);
      beat_t bt;
      int    nb;
      int    pos;
      pkt.delete();
      if (len == 0) begin
         bt.d = 32'h0; bt.k = 4'h0; bt.l = 1'b1;
         pkt.push_back(bt);
         return;
      end
      nb = (len + 3) / 4;
      for (int bi = 0; bi < nb; bi++) begin
         bt.d = 32'h0; bt.k = 4'h0;
         for (int ln = 0; ln < 4; ln++) begin
            pos = bi * 4 + ln;
            if (pos < len) begin
               bt.d[8*ln +: 8] = 8'(len - 1 - pos);
               bt.k[ln] = 1'b1;
            end
         end
         bt.l = (bi == nb - 1) && !trailer;
         pkt.push_back(bt);
      end
      if (trailer) begin
         bt.d = 32'h0; bt.k = 4'h0; bt.l = 1'b1;
         pkt.push_back(bt);
      end
   endtask

   task automatic send_beat(input beat_t bt);
      int n;
      i_tvalid = 1'b1; i_tdata = bt.d; i_tkeep = bt.k; i_tlast = bt.l;
      n = 0;
      @(negedge clk);
      while (!i_tready1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("beat_accept_in_time", (n < 100), 1);
      @(posedge clk);
      #1;
      i_tvalid = 1'b0; i_tdata = 32'h0; i_tkeep = 4'h0; i_tlast = 1'b0;
   endtask

   task automatic send_pkt();
      logic [39:0] r1, r0;
      r1 = model(1'b1);
      r0 = model(1'b0);
      for (int i = 0; i < 5; i++) begin
         exp1.push_back(r1[8*i +: 8]);
         exp0.push_back(r0[8*i +: 8]);
      end
      foreach (pkt[i]) send_beat(pkt[i]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((pending || exp1.size() != 0) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("report_done_in_time", (n < 2000), 1);
   endtask

   // Sink ready: always 1 unless random stall mode is on.
   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         o_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Per-cycle monitor: handshake shape, byte hold during stalls, and report bytes in order.
   always @(negedge clk) begin
      if (!rstn) begin
         pending = 1'b0;
         idx     = 0;
         stalled = 1'b0;
      end else begin
         chk("o_tvalid", o_tvalid1, pending);
         chk("o_tvalid_nz", o_tvalid0, pending);
         chk("i_tready", i_tready1, !pending);
         chk("i_tready_nz", i_tready0, !pending);
         if (stalled) begin
            chk("hold_vld", o_tvalid1, 1);
            chk("hold_dat", o_tdata1, held1);
            chk("hold_dat_nz", o_tdata0, held0);
         end
         stalled = o_tvalid1 && !o_tready;
         held1   = o_tdata1;
         held0   = o_tdata0;
         if (o_tvalid1 && o_tready) begin
            if (exp1.size() == 0 || exp0.size() == 0) begin
               chk("unexpected_byte", exp1.size(), 1);
            end else begin
               chk($sformatf("report_byte%0d", idx), o_tdata1, exp1.pop_front());
               chk($sformatf("report_byte%0d_nz", idx), o_tdata0, exp0.pop_front());
            end
            idx++;
            if (idx == 5) begin
               idx     = 0;
               pending = 1'b0;
            end
         end
         if (i_tvalid && i_tready1 && i_tlast) pending = 1'b1;
      end
   end

   initial begin
      beat_t bt;
      int    n;
      rstn = 1'b0; i_tvalid = 1'b0; i_tdata = 32'h0; i_tkeep = 4'h0; i_tlast = 1'b0;
      #1;
      chk("rst_o_tvalid", o_tvalid1, 0);
      chk("rst_o_tdata", o_tdata1, 8'h00);
      chk("rst_i_tready", i_tready1, 1);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Length 10, tail in a partial beat; sink busy for exactly 5 cycles.
      build_pkt(10, 1'b0);
      chk("t1_model", model(1'b1), 40'h00_0000000A);
      send_pkt();
      n = 0;
      while (!i_tready1 && n < 50) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("t1_tready_low_cycles", n, 5);
      wait_idle();

      // Length 8 with keep=0 trailer, then zero-length packet.
      build_pkt(8, 1'b1);
      chk("t2_model", model(1'b1), 40'h00_00000008);
      send_pkt();
      wait_idle();
      build_pkt(0, 1'b0);
      chk("t2_zero_model", model(1'b1), 40'h00_00000000);
      send_pkt();
      wait_idle();

      // Corrupted byte 0x05 -> 0x55, then a clean packet clears status.
      build_pkt(10, 1'b0);
      pkt[1].d[7:0] = 8'h55;
      chk("t3_model", model(1'b1), 40'h01_0000000A);
      send_pkt();
      wait_idle();
      build_pkt(10, 1'b0);
      send_pkt();
      wait_idle();

      // Illegal keep=0101 in mid-packet with a consistent pattern.
      pkt.delete();
      bt.d = 32'h06070809; bt.k = 4'hF;    bt.l = 1'b0; pkt.push_back(bt);
      bt.d = 32'h00040005; bt.k = 4'b0101; bt.l = 1'b0; pkt.push_back(bt);
      bt.d = 32'h00010203; bt.k = 4'hF;    bt.l = 1'b1; pkt.push_back(bt);
      chk("t4_keep_model", model(1'b1), 40'h02_0000000A);
      send_pkt();
      wait_idle();

      // Packet ending in 0x01: status 0x04 with the check on, 0x00 with it off.
      pkt.delete();
      bt.d = 32'h0708090A; bt.k = 4'hF;    bt.l = 1'b0; pkt.push_back(bt);
      bt.d = 32'h03040506; bt.k = 4'hF;    bt.l = 1'b0; pkt.push_back(bt);
      bt.d = 32'h00000102; bt.k = 4'b0011; bt.l = 1'b1; pkt.push_back(bt);
      chk("t4_last_model", model(1'b1), 40'h04_0000000A);
      chk("t4_last_model_nz", model(1'b0), 40'h00_0000000A);
      send_pkt();
      wait_idle();

      // Length 300: byte wrap and carry into count[15:8].
      build_pkt(300, 1'b0);
      chk("t5_first_byte", pkt[0].d[7:0], 8'h2B);
      chk("t5_model", model(1'b1), 40'h00_0000012C);
      send_pkt();
      wait_idle();

      // Random sink stalls during reports.
      rnd_mode = 1'b1;
      build_pkt(10, 1'b0);
      send_pkt();
      wait_idle();
      build_pkt(7, 1'b0);
      send_pkt();
      wait_idle();
      rnd_mode = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of a report, then a fresh packet.
      build_pkt(10, 1'b0);
      send_pkt();
      @(posedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_o_tvalid", o_tvalid1, 0);
      chk("midrst_i_tready", i_tready1, 1);
      chk("midrst_o_tvalid_nz", o_tvalid0, 0);
      chk("midrst_i_tready_nz", i_tready0, 1);
      exp1.delete();
      exp0.delete();
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      build_pkt(5, 1'b0);
      chk("t6_model", model(1'b1), 40'h00_00000005);
      send_pkt();
      wait_idle();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
